// File: rtl/filter_mem_node_mc_if.sv
// Filter memory node bus: filter byte write channel plus packet output channel.
// Latency: none; this is a bundle of wires only.
// Backpressure: wr_ready gates writes; out_ready stalls packet output.
// Ports: wr_valid/wr_ready/wr_addr/wr_data (byte write), out_valid/out_ready/out_packet (NoC packet).
// The master modport is the filter node's view; the slave modport is its environment.
interface filter_mem_node_mc_if #(
  parameter int WIDTH_data   = 8,
  parameter int WIDTH_addr   = 12,
  parameter int WIDTH_packet = 57
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [WIDTH_addr-1:0]   wr_addr;
  logic [WIDTH_data-1:0]   wr_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH_packet-1:0] out_packet;

  modport master (
    input  wr_valid, wr_addr, wr_data, out_ready,
    output wr_ready, out_valid, out_packet
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, out_ready,
    input  wr_ready, out_valid, out_packet
  );
endinterface

// File: rtl/filter_mem_node_mc.sv
// Filter memory node: stores NUM_FILTERS KxK byte filters, then streams one packet per filter row to PEs.
// Latency: first packet valid 1 cycle after entering SEND; then one packet per cycle while out_ready is high.
// Backpressure: out_packet/out_valid held while out_ready is low; wr_ready is high only in LOAD.
// Ports: clk, rst_n (async active-low), load_start_i/load_done_i/resend_i control pulses,
//        busy_o (state != IDLE), addr_err_o (sticky out-of-range write), bus (write + packet channels).
module filter_mem_node_mc #(
  parameter int NODE          = 11,
  parameter int K             = 5,
  parameter int NUM_FILTERS   = 2,
  parameter int PE_BASE       = 1,
  parameter int WIDTH_data    = 8,
  parameter int WIDTH_addr    = 12,
  parameter int WIDTH_payload = 40,
  parameter int WIDTH_packet  = 57
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_i,
  input  logic                  load_done_i,
  input  logic                  resend_i,
  output logic                  busy_o,
  output logic                  addr_err_o,
  filter_mem_node_mc_if.master  bus
);

  localparam int DEPTH = NUM_FILTERS * K * K;
  localparam int NPKT  = NUM_FILTERS * K;
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                  state_q;
  logic                    en_q;
  logic                    out_valid_q;
  logic [WIDTH_packet-1:0] out_packet_q, out_packet_d;
  logic [6:0]              seq_q, seq_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    addr_err_q;
  logic [WIDTH_data-1:0]   mem_q [DEPTH];
  logic [WIDTH_payload-1:0] payload_d;
  logic                    wr_fire;
  logic                    addr_ok;
  logic                    last_pkt;
  int                      idx;

  // en_q stays low for the first edge after reset release so no input is acted on in that cycle.
  assign wr_fire  = en_q && (state_q == LOAD) && bus.wr_valid;
  assign addr_ok  = bus.wr_addr < WIDTH_addr'(DEPTH);
  assign last_pkt = (seq_q == 7'(NPKT - 1));

  assign bus.wr_ready   = (state_q == LOAD);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_packet = out_packet_q;
  assign busy_o         = (state_q != IDLE);
  assign addr_err_o     = addr_err_q;

  // Next packet to present: the current index when nothing is shown yet, otherwise the one after.
  // A row's bytes sit contiguously at (f*K + r)*K, which is simply seq*K.
  always_comb begin
    seq_d     = seq_q;
    row_d     = row_q;
    payload_d = '0;
    idx       = 0;
    if (out_valid_q) begin
      seq_d = seq_q + 7'd1;
      row_d = (row_q == RW'(K - 1)) ? '0 : row_q + RW'(1);
    end
    for (int c = 0; c < K; c++) begin
      idx = int'(seq_d) * K + c;
      if (idx < DEPTH) begin
        payload_d[c*WIDTH_data +: WIDTH_data] = mem_q[MW'(idx)];
      end
    end
    // Destination wraps modulo 16.
    out_packet_d = {4'(NODE), 4'(PE_BASE) + 4'(row_d), 2'b01, seq_d, payload_d};
  end

  // Filter storage; out-of-range writes are handshaken but discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire && addr_ok) begin
      mem_q[MW'(bus.wr_addr)] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      seq_q        <= '0;
      row_q        <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (en_q) begin
        case (state_q)
          IDLE: begin
            if (load_start_i) begin
              state_q    <= LOAD;
              addr_err_q <= 1'b0;
            end else if (resend_i) begin
              state_q <= SEND;
              seq_q   <= '0;
              row_q   <= '0;
            end
          end
          LOAD: begin
            if (wr_fire && !addr_ok) begin
              addr_err_q <= 1'b1;
            end
            // A write in the same cycle as load_done lands in memory before the first packet is built.
            if (load_done_i) begin
              state_q <= SEND;
              seq_q   <= '0;
              row_q   <= '0;
            end
          end
          SEND: begin
            if (!out_valid_q) begin
              out_valid_q  <= 1'b1;
              out_packet_q <= out_packet_d;
            end else if (bus.out_ready) begin
              if (last_pkt) begin
                out_valid_q <= 1'b0;
                state_q     <= IDLE;
                seq_q       <= '0;
                row_q       <= '0;
              end else begin
                seq_q        <= seq_d;
                row_q        <= row_d;
                out_packet_q <= out_packet_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
